radiant_scaler_bank: RTL and testbench

- Per-channel trigger rate scaler bank, downstream of the trigger top's single-channel scaler flags (scal_o[23:0], clk_i domain, one-cycle flags from each channel oneshot).
- Counts flags over a gate period set by PPS, or by an internal timer when PPS is absent.
- Double-buffers the counts so software reads a coherent snapshot.
- Feeds the trigger control register space through a simple registered read port.

---
 rtl/radiant_scaler_bank.sv | 279 +++++++++++++++++++++++++++
 tb/tb_radiant_scaler_bank.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radiant_scaler_bank.sv
`default_nettype none
// ============================================================================
// Module      : radiant_scaler_bank
// Description : Per-channel trigger rate scaler bank. Counts one-cycle scaler
//               flags over a gate period defined by PPS (with an internal
//               timer as fallback), double-buffers the counts into holding
//               registers, and exposes them through a registered read port.
//
//               Optional build macro: RADIANT_SCALER_OVF_EN
//                 defined   -> sticky per-channel overflow bit, reported in
//                              dat_o[31] and on the ovf_o port.
//                 undefined -> no ovf_o port, dat_o[31] = 0.
//
// Ports       : clk_i         system clock
//               rst_i         synchronous active-high reset
//               scal_i        per-channel scaler flags (one count per cycle)
//               pps_i         single-cycle PPS flag, clk_i domain
//               use_pps_i     1 = PPS gating with timeout fallback
//               freeze_i      defers snapshot updates while software reads
//               sel_i         readout channel select
//               dat_o         registered readout data
//               update_o      one-cycle pulse when a snapshot lands in hold
//               gate_src_o    source of last snapshot (1 = PPS)
//               ovf_o         latched overflow bits (optional)
//               period_cnt_o  snapshots latched since reset (wraps)
//
// Revision    : 1.0  initial release
// ============================================================================
module radiant_scaler_bank #(
    parameter int NUM_CH           = 24,
    parameter int SCALER_WIDTH     = 16,
    parameter int PERIOD_CLKS      = 50000000,
    parameter int PPS_TIMEOUT_CLKS = 60000000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_CH-1:0]   scal_i,
    input  logic                pps_i,
    input  logic                use_pps_i,
    input  logic                freeze_i,
    input  logic [4:0]          sel_i,
    output logic [31:0]         dat_o,
    output logic                update_o,
    output logic                gate_src_o,
`ifdef RADIANT_SCALER_OVF_EN
    output logic [NUM_CH-1:0]   ovf_o,
`endif
    output logic [15:0]         period_cnt_o
);

    localparam int c_TMR_W = $clog2(PERIOD_CLKS + 1);
    localparam int c_TO_W  = $clog2(PPS_TIMEOUT_CLKS + 1);

    localparam logic [c_TMR_W-1:0]      c_TMR_LAST = c_TMR_W'(PERIOD_CLKS - 1);
    localparam logic [c_TO_W-1:0]       c_TO_MAX   = c_TO_W'(PPS_TIMEOUT_CLKS);
    localparam logic [SCALER_WIDTH-1:0] c_CNT_MAX  = '1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_PEND = 1'b1;

    // ------------------------------------------------------------------
    // Gate generation
    // ------------------------------------------------------------------
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_TO_W-1:0]  r_to_tmr;
    logic               w_gate_int;
    logic               w_pps_mode;
    logic               w_gate;

    assign w_gate_int = (r_tmr == c_TMR_LAST);
    assign w_pps_mode = use_pps_i && (r_to_tmr < c_TO_MAX);
    assign w_gate     = w_pps_mode ? pps_i : w_gate_int;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmr    <= '0;
            r_to_tmr <= '0;
        end else begin
            // Clearing on an accepted PPS means a fallback gate arrives a
            // full period after the last PPS rather than at a random phase.
            if ((w_pps_mode && pps_i) || w_gate_int) begin
                r_tmr <= '0;
            end else begin
                r_tmr <= r_tmr + 1'b1;
            end

            if (pps_i) begin
                r_to_tmr <= '0;
            end else if (r_to_tmr != c_TO_MAX) begin
                r_to_tmr <= r_to_tmr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot state machine
    // ------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       w_snap_live;   // hold <= live counters
    logic       w_snap_pend;   // hold <= parked pending counts
    logic       w_to_pend;     // pending <= live counters

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_gate && freeze_i) w_state_nxt = c_ST_PEND;
            c_ST_PEND: if (!freeze_i)          w_state_nxt = c_ST_IDLE;
            default:                           w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_snap_live = 1'b0;
        w_snap_pend = 1'b0;
        w_to_pend   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_snap_live = w_gate && !freeze_i;
                w_to_pend   = w_gate && freeze_i;
            end
            c_ST_PEND: begin
                // A gate on the unfreeze cycle carries newer counts than the
                // parked ones, so the live counters go straight to hold.
                w_snap_live = w_gate && !freeze_i;
                w_snap_pend = !w_gate && !freeze_i;
                w_to_pend   = w_gate && freeze_i;
            end
            default: begin
                w_snap_live = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Snapshot bookkeeping
    // ------------------------------------------------------------------
    logic        r_update;
    logic [15:0] r_period_cnt;
    logic        r_gate_src;
    logic        r_pend_src;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_update     <= 1'b0;
            r_period_cnt <= '0;
            r_gate_src   <= 1'b0;
            r_pend_src   <= 1'b0;
        end else begin
            r_update <= w_snap_live || w_snap_pend;
            if (w_snap_live || w_snap_pend) begin
                r_period_cnt <= r_period_cnt + 16'd1;
            end
            if (w_snap_live) begin
                r_gate_src <= w_pps_mode;
            end else if (w_snap_pend) begin
                r_gate_src <= r_pend_src;
            end
            if (w_to_pend) begin
                r_pend_src <= w_pps_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel counters, pending and holding registers
    // ------------------------------------------------------------------
    logic [SCALER_WIDTH-1:0] w_hold [NUM_CH];
    logic [NUM_CH-1:0]       w_hold_ovf;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SCALER_WIDTH-1:0] r_cnt;
            logic [SCALER_WIDTH-1:0] r_pend;
            logic [SCALER_WIDTH-1:0] r_hold;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt  <= '0;
                    r_pend <= '0;
                    r_hold <= '0;
                end else begin
                    // A flag on the gate cycle belongs to the new period.
                    if (w_gate) begin
                        r_cnt <= SCALER_WIDTH'(scal_i[gi]);
                    end else if (scal_i[gi] && (r_cnt != c_CNT_MAX)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_to_pend) begin
                        r_pend <= r_cnt;
                    end
                    if (w_snap_live) begin
                        r_hold <= r_cnt;
                    end else if (w_snap_pend) begin
                        r_hold <= r_pend;
                    end
                end
            end

            assign w_hold[gi] = r_hold;

`ifdef RADIANT_SCALER_OVF_EN
            logic r_ovf;
            logic r_pend_ovf;
            logic r_hold_ovf;

            // Sticky: set when a flag arrives while the counter is pinned at
            // its ceiling, i.e. when a count has actually been lost.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_ovf      <= 1'b0;
                    r_pend_ovf <= 1'b0;
                    r_hold_ovf <= 1'b0;
                end else begin
                    if (w_gate) begin
                        r_ovf <= 1'b0;
                    end else if (scal_i[gi] && (r_cnt == c_CNT_MAX)) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_to_pend) begin
                        r_pend_ovf <= r_ovf;
                    end
                    if (w_snap_live) begin
                        r_hold_ovf <= r_ovf;
                    end else if (w_snap_pend) begin
                        r_hold_ovf <= r_pend_ovf;
                    end
                end
            end

            assign w_hold_ovf[gi] = r_hold_ovf;
`else
            assign w_hold_ovf[gi] = 1'b0;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered readout
    // ------------------------------------------------------------------
    logic [31:0] w_rd;
    logic [31:0] r_dat;

    always_comb begin
        w_rd = '0;
        if (int'(sel_i) < NUM_CH) begin
            w_rd[SCALER_WIDTH-1:0] = w_hold[sel_i];
            w_rd[31]               = w_hold_ovf[sel_i];
        end else if (sel_i == 5'd31) begin
            w_rd[15:0] = r_period_cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dat <= '0;
        end else begin
            r_dat <= w_rd;
        end
    end

    assign dat_o        = r_dat;
    assign update_o     = r_update;
    assign gate_src_o   = r_gate_src;
    assign period_cnt_o = r_period_cnt;
`ifdef RADIANT_SCALER_OVF_EN
    assign ovf_o        = w_hold_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_radiant_scaler_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_radiant_scaler_bank
// Description : Self-checking bench for radiant_scaler_bank. A behavioural
//               reference model applies the scaler rules per clock with plain
//               integer arrays; directed scenarios add fixed expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_radiant_scaler_bank;

    localparam int NUM_CH = 24;
    localparam int SW     = 8;
    localparam int PER    = 100;
    localparam int TO     = 400;
    localparam int MAXC   = (1 << SW) - 1;
`ifdef RADIANT_SCALER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] scal = '0;
    logic              pps = 1'b0;
    logic              use_pps = 1'b0;
    logic              freeze = 1'b0;
    logic [4:0]        sel = '0;
    logic [31:0]       dat;
    logic              upd;
    logic              src;
    logic [15:0]       pcnt;
`ifdef RADIANT_SCALER_OVF_EN
    logic [NUM_CH-1:0] ovf;
`endif

    radiant_scaler_bank #(
        .NUM_CH           (NUM_CH),
        .SCALER_WIDTH     (SW),
        .PERIOD_CLKS      (PER),
        .PPS_TIMEOUT_CLKS (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .scal_i       (scal),
        .pps_i        (pps),
        .use_pps_i    (use_pps),
        .freeze_i     (freeze),
        .sel_i        (sel),
        .dat_o        (dat),
        .update_o     (upd),
        .gate_src_o   (src),
`ifdef RADIANT_SCALER_OVF_EN
        .ovf_o        (ovf),
`endif
        .period_cnt_o (pcnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int          m_cnt [NUM_CH];
    int          m_pend[NUM_CH];
    int          m_hold[NUM_CH];
    bit          m_ovf [NUM_CH];
    bit          m_pend_ovf[NUM_CH];
    bit          m_hold_ovf[NUM_CH];
    bit          m_pending, m_pend_src, m_src, m_update;
    int          m_tmr, m_to;
    logic [15:0] m_pcnt;
    logic [31:0] m_dat;

    task automatic model_step();
        bit          pps_mode, gate;
        logic [31:0] nd;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_cnt[i] = 0; m_pend[i] = 0; m_hold[i] = 0;
                m_ovf[i] = 0; m_pend_ovf[i] = 0; m_hold_ovf[i] = 0;
            end
            m_pending = 0; m_pend_src = 0; m_src = 0; m_update = 0;
            m_tmr = 0; m_to = 0; m_pcnt = 0; m_dat = 0;
            return;
        end
        pps_mode = use_pps && (m_to < TO);
        gate     = pps_mode ? pps : (m_tmr == PER - 1);

        nd = 0;
        if (int'(sel) < NUM_CH) begin
            nd = 32'(m_hold[sel]);
            if (OVF_EN && m_hold_ovf[sel]) nd[31] = 1'b1;
        end else if (sel == 5'd31) begin
            nd = {16'h0, m_pcnt};
        end

        m_update = 0;
        if (gate && !freeze) begin
            m_hold = m_cnt; m_hold_ovf = m_ovf;
            m_update = 1; m_pcnt++; m_src = pps_mode; m_pending = 0;
        end else if (gate && freeze) begin
            m_pend = m_cnt; m_pend_ovf = m_ovf;
            m_pend_src = pps_mode; m_pending = 1;
        end else if (m_pending && !freeze) begin
            m_hold = m_pend; m_hold_ovf = m_pend_ovf;
            m_update = 1; m_pcnt++; m_src = m_pend_src; m_pending = 0;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (gate) begin
                m_cnt[i] = scal[i] ? 1 : 0;
                m_ovf[i] = 0;
            end else if (scal[i]) begin
                if (m_cnt[i] == MAXC) m_ovf[i] = 1;
                else                  m_cnt[i]++;
            end
        end

        m_tmr = ((pps_mode && pps) || m_tmr == PER - 1) ? 0 : m_tmr + 1;
        m_to  = pps ? 0 : ((m_to < TO) ? m_to + 1 : TO);
        m_dat = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; scal = '0; pps = 0; use_pps = 0; freeze = 0; sel = 0;
        tick(); tick();
        if (dat !== 32'd0 || upd !== 1'b0 || src !== 1'b0 || pcnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: dat=%h upd=%b src=%b pcnt=%0d, required all zero", dat, upd, src, pcnt);
        end
        n_tests++;
        rst = 0;
    endtask

    task automatic test_internal_gate();
        int first = -1;
        scal = 24'h8; sel = 5'd3; use_pps = 0;
        for (int k = 1; k <= PER + 3; k++) begin
            if (k == PER + 2) sel = 5'd5;
            if (k == PER + 3) sel = 5'd31;
            tick();
            if (dat !== m_dat || upd !== m_update || src !== m_src || pcnt !== m_pcnt) begin
                n_fail++;
                $display("FAIL internal_model k=%0d: dat=%h/%h upd=%b/%b src=%b/%b pcnt=%0d/%0d",
                         k, dat, m_dat, upd, m_update, src, m_src, pcnt, m_pcnt);
            end
            n_tests++;
            if (upd === 1'b1 && first < 0) first = k;
            // ch3 high every cycle: edges 1..PER-1 count, the gate-edge flag starts the next period
            if (k == PER + 1) begin
                if (dat !== 32'(PER - 1)) begin
                    n_fail++; $display("FAIL internal_ch3: got %0d, required %0d", dat, PER - 1);
                end
                n_tests++;
            end
            if (k == PER + 2) begin
                if (dat !== 32'd0) begin
                    n_fail++; $display("FAIL internal_ch5: got %0d, required 0", dat);
                end
                n_tests++;
            end
            if (k == PER + 3) begin
                if (dat !== 32'd1) begin
                    n_fail++; $display("FAIL internal_sel31: got %0d, required 1", dat);
                end
                n_tests++;
            end
        end
        if (first != PER) begin
            n_fail++; $display("FAIL internal_first_update: at clock %0d, required %0d", first, PER);
        end
        n_tests++;
        scal = '0;
    endtask

    task automatic test_pps_count();
        int nupd;
        use_pps = 1; sel = 5'd0;
        for (int iv = 0; iv < 4; iv++) begin
            nupd = 0;
            for (int j = 0; j < 350; j++) begin
                pps = (j == 349);
                scal = '0;
                scal[0]  = (j % 50 == 10);
                scal[10] = ($urandom_range(0, 3) == 0);
                tick();
                if (dat !== m_dat || upd !== m_update || src !== m_src || pcnt !== m_pcnt) begin
                    n_fail++;
                    $display("FAIL pps_model iv=%0d j=%0d: dat=%h/%h upd=%b/%b src=%b/%b pcnt=%0d/%0d",
                             iv, j, dat, m_dat, upd, m_update, src, m_src, pcnt, m_pcnt);
                end
                n_tests++;
                if (upd === 1'b1) nupd++;
            end
            if (iv >= 2) begin
                if (nupd != 1 || src !== 1'b1) begin
                    n_fail++; $display("FAIL pps_one_update iv=%0d: updates %0d src %b, required 1 and 1", iv, nupd, src);
                end
                n_tests++;
            end
        end
        pps = 0; scal = '0;
        tick();
        if (dat !== 32'd7) begin
            n_fail++; $display("FAIL pps_ch0_count: got %0d, required 7", dat);
        end
        n_tests++;
    endtask

    task automatic test_timeout();
        int first = -1;
        pps = 1; tick(); pps = 0;
        for (int k = 1; k <= 700; k++) begin
            scal = NUM_CH'($urandom) & NUM_CH'($urandom);
            sel  = 5'($urandom_range(0, 31));
            tick();
            if (dat !== m_dat || upd !== m_update || src !== m_src || pcnt !== m_pcnt) begin
                n_fail++;
                $display("FAIL timeout_model k=%0d: dat=%h/%h upd=%b/%b src=%b/%b pcnt=%0d/%0d",
                         k, dat, m_dat, upd, m_update, src, m_src, pcnt, m_pcnt);
            end
            n_tests++;
            if (upd === 1'b1 && first < 0) first = k;
        end
        // first internal gate: the first timer wrap after the timeout has expired
        if (first != ((TO + PER) / PER) * PER || src !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fallback: first update %0d src %b, required %0d and 0",
                     first, src, ((TO + PER) / PER) * PER);
        end
        n_tests++;
        // PPS returns: first pulse re-arms, the next one gates
        for (int k = 0; k < 600; k++) begin
            pps  = (k == 0 || k == 299 || k == 599);
            scal = NUM_CH'($urandom) & NUM_CH'($urandom);
            tick();
            if (dat !== m_dat || upd !== m_update || src !== m_src || pcnt !== m_pcnt) begin
                n_fail++;
                $display("FAIL timeout_return_model k=%0d: dat=%h/%h upd=%b/%b src=%b/%b pcnt=%0d/%0d",
                         k, dat, m_dat, upd, m_update, src, m_src, pcnt, m_pcnt);
            end
            n_tests++;
        end
        if (upd !== 1'b1 || src !== 1'b1) begin
            n_fail++; $display("FAIL timeout_pps_return: upd %b src %b, required 1 and 1", upd, src);
        end
        n_tests++;
        pps = 0; scal = '0;
    endtask

    task automatic test_freeze();
        bit          found = 0;
        int          nupd  = 0;
        logic [15:0] p0;
        use_pps = 0; freeze = 0; scal = '0; sel = 5'd1;
        for (int k = 0; k < PER + 5 && !found; k++) begin
            tick();
            if (upd === 1'b1) found = 1;
        end
        if (!found) begin
            n_fail++; $display("FAIL freeze_sync: no update_o within %0d clocks, required one", PER + 5);
        end
        n_tests++;
        freeze = 1;
        for (int j = 1; j <= 220; j++) begin
            scal = '0;
            scal[1] = (j <= 5) || (j >= 101 && j <= 109);
            tick();
            if (dat !== m_dat || upd !== m_update || src !== m_src || pcnt !== m_pcnt) begin
                n_fail++;
                $display("FAIL freeze_model j=%0d: dat=%h/%h upd=%b/%b src=%b/%b pcnt=%0d/%0d",
                         j, dat, m_dat, upd, m_update, src, m_src, pcnt, m_pcnt);
            end
            n_tests++;
            if (upd === 1'b1) nupd++;
        end
        if (nupd != 0) begin
            n_fail++; $display("FAIL freeze_no_update: %0d updates while frozen, required 0", nupd);
        end
        n_tests++;
        p0 = m_pcnt;
        freeze = 0; scal = '0;
        tick();
        if (upd !== 1'b1 || pcnt !== p0 + 16'd1) begin
            n_fail++; $display("FAIL freeze_release: upd %b pcnt %0d, required 1 and %0d", upd, pcnt, p0 + 16'd1);
        end
        n_tests++;
        tick();
        if (dat !== 32'd9 || upd !== 1'b0) begin
            n_fail++; $display("FAIL freeze_newest_wins: dat %0d upd %b, required 9 and 0", dat, upd);
        end
        n_tests++;
    endtask

    task automatic test_coincident();
        bit found = 0;
        use_pps = 0; freeze = 0; scal = '0; sel = 5'd2;
        for (int k = 0; k < PER + 5 && !found; k++) begin
            tick();
            if (upd === 1'b1) found = 1;
        end
        if (!found) begin
            n_fail++; $display("FAIL coinc_sync: no update_o within %0d clocks, required one", PER + 5);
        end
        n_tests++;
        for (int j = 1; j <= 3 * PER; j++) begin
            scal = '0;
            scal[2] = (j == PER || j == PER + 50);
            rst = (j == 3 * PER);
            tick();
            if (dat !== m_dat || upd !== m_update || src !== m_src || pcnt !== m_pcnt) begin
                n_fail++;
                $display("FAIL coinc_model j=%0d: dat=%h/%h upd=%b/%b src=%b/%b pcnt=%0d/%0d",
                         j, dat, m_dat, upd, m_update, src, m_src, pcnt, m_pcnt);
            end
            n_tests++;
            if (j == PER + 1) begin
                if (dat !== 32'd0) begin
                    n_fail++; $display("FAIL coinc_old_period: got %0d, required 0", dat);
                end
                n_tests++;
            end
            if (j == 2 * PER + 1) begin
                if (dat !== 32'd2) begin
                    n_fail++; $display("FAIL coinc_new_period: got %0d, required 2", dat);
                end
                n_tests++;
            end
        end
        if (upd !== 1'b0 || dat !== 32'd0 || pcnt !== 16'd0 || src !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_reset_wins: upd %b dat %h pcnt %0d src %b, required all zero", upd, dat, pcnt, src);
        end
        n_tests++;
        rst = 0; scal = '0;
    endtask

    task automatic test_saturation();
        logic [31:0] exp_sat;
        use_pps = 1; freeze = 0; sel = 5'd4;
        exp_sat = 32'(MAXC);
        if (OVF_EN) exp_sat[31] = 1'b1;
        for (int iv = 0; iv < 3; iv++) begin
            for (int j = 0; j < 350; j++) begin
                pps = (j == 349);
                scal = '0;
                scal[4] = (iv == 1) ? (j < 349) : (iv == 2 && (j == 10 || j == 20));
                tick();
                if (dat !== m_dat || upd !== m_update || src !== m_src || pcnt !== m_pcnt) begin
                    n_fail++;
                    $display("FAIL sat_model iv=%0d j=%0d: dat=%h/%h upd=%b/%b src=%b/%b pcnt=%0d/%0d",
                             iv, j, dat, m_dat, upd, m_update, src, m_src, pcnt, m_pcnt);
                end
                n_tests++;
            end
            pps = 0; scal = '0;
            tick();
            if (iv == 1) begin
                if (dat !== exp_sat) begin
                    n_fail++; $display("FAIL sat_clamp: got %h, required %h", dat, exp_sat);
                end
                n_tests++;
`ifdef RADIANT_SCALER_OVF_EN
                if (ovf[4] !== 1'b1) begin
                    n_fail++; $display("FAIL sat_ovf_set: ovf_o[4]=%b, required 1", ovf[4]);
                end
                n_tests++;
`endif
            end
            if (iv == 2) begin
                if (dat !== 32'd2) begin
                    n_fail++; $display("FAIL sat_recover: got %h, required 2", dat);
                end
                n_tests++;
`ifdef RADIANT_SCALER_OVF_EN
                if (ovf[4] !== 1'b0) begin
                    n_fail++; $display("FAIL sat_ovf_clear: ovf_o[4]=%b, required 0", ovf[4]);
                end
                n_tests++;
`endif
            end
        end
    endtask

    task automatic test_random();
        int gap = 200;
        int dens[NUM_CH];
        for (int i = 0; i < NUM_CH; i++) dens[i] = (i * 37) % 101;
        dens[NUM_CH-1] = 100;
        for (int c = 0; c < 4000; c++) begin
            if (c % 1000 == 0) use_pps = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) freeze = ~freeze;
            if (gap == 0) gap = $urandom_range(150, 450);
            else          gap--;
            pps = (gap == 0);
            rst = ($urandom_range(0, 1999) == 0);
            sel = 5'($urandom_range(0, 31));
            for (int i = 0; i < NUM_CH; i++) scal[i] = ($urandom_range(0, 99) < dens[i]);
            tick();
            if (dat !== m_dat || upd !== m_update || src !== m_src || pcnt !== m_pcnt) begin
                n_fail++;
                $display("FAIL random_model c=%0d: dat=%h/%h upd=%b/%b src=%b/%b pcnt=%0d/%0d",
                         c, dat, m_dat, upd, m_update, src, m_src, pcnt, m_pcnt);
            end
            n_tests++;
`ifdef RADIANT_SCALER_OVF_EN
            for (int i = 0; i < NUM_CH; i++) begin
                if (ovf[i] !== m_hold_ovf[i]) begin
                    n_fail++; $display("FAIL random_ovf c=%0d ch=%0d: got %b, required %b", c, i, ovf[i], m_hold_ovf[i]);
                end
                n_tests++;
            end
`endif
        end
        rst = 0; pps = 0; freeze = 0; scal = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_internal_gate();
        test_pps_count();
        test_timeout();
        test_freeze();
        test_coincident();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
